// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the MEM-stage miss/branch controller.
//   mem_state_e     - controller state encoding
//   TIMEOUT_DEF     - default REQ-cycle budget before a timeout error
//   CNT_WIDTH_DEF   - default width of the saturating miss counter
//   wait_cnt_width  - width needed by the REQ wait counter for a given budget
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    ERROR = 2'd3
  } mem_state_e;

  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam int unsigned CNT_WIDTH_DEF = 16;

  // The wait counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset (count -> 0)
//   clr_i  - synchronous clear, has priority over inc_i
//   inc_i  - increment request
//   cnt_o  - current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_stage_controller.sv
// mem_stage_controller: MEM-stage sequencer sitting behind the EX/MEM register.
// A cache miss freezes the pipeline, issues a backing-memory transaction and
// releases the pipeline for one FILL cycle with the refill data. Taken branches
// are resolved into pcSrc/flush, held off while the pipeline is frozen.
//   clock, resetN                  - clock / async active-low reset
//   memReadIn, memWriteIn, hitIn   - EX/MEM memory controls and cache hit
//   branchIn, zeroFlagIn           - EX/MEM branch resolution inputs
//   addrIn, wdataIn                - effective address and store data
//   memAck, memRdata               - backing memory completion pulse and read data
//   stall, bubble                  - pipeline freeze / MEM/WB NOP insert (comb)
//   pcSrc, flush                   - taken-branch redirect (comb)
//   memReq, memWe, memAddr, memWdata - registered backing-memory request
//   fillValid, fillData            - registered read-miss completion
//   timeoutErr                     - sticky timeout flag
//   missCount                      - saturating miss counter
module mem_stage_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  memReadIn,
  input  logic                  memWriteIn,
  input  logic                  hitIn,
  input  logic                  branchIn,
  input  logic                  zeroFlagIn,
  input  logic [ADDR_WIDTH-1:0] addrIn,
  input  logic [DATA_WIDTH-1:0] wdataIn,
  input  logic                  memAck,
  input  logic [DATA_WIDTH-1:0] memRdata,
  output logic                  stall,
  output logic                  bubble,
  output logic                  pcSrc,
  output logic                  flush,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  output logic                  fillValid,
  output logic [DATA_WIDTH-1:0] fillData,
  output logic                  timeoutErr,
  output logic [CNT_WIDTH-1:0]  missCount
);

  localparam int unsigned          WAIT_W    = wait_cnt_width(TIMEOUT);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  mem_state_e            state_q;
  logic                  memReq_q;
  logic                  memWe_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q;
  logic                  fillValid_q;
  logic [DATA_WIDTH-1:0] fillData_q;
  logic                  timeoutErr_q;

  logic                  miss;
  logic                  miss_start;
  logic                  wait_inc;
  logic                  wait_clr;
  logic                  wait_expired;
  logic [WAIT_W-1:0]     wait_cnt;

  // A simultaneous read+write request is handled as a write via memWe.
  assign miss       = (memReadIn | memWriteIn) & ~hitIn;
  assign miss_start = (state_q == IDLE) & miss;

  // Wait counter is zero on REQ entry; REQ cycle n sees n-1, so the budget
  // expires at the end of the TIMEOUT-th REQ cycle.
  assign wait_clr     = (state_q != REQ);
  assign wait_inc     = (state_q == REQ) & ~memAck;
  assign wait_expired = (state_q == REQ) & ~memAck & (wait_cnt == WAIT_LAST);

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_miss_cnt (
    .clk_i  (clock),
    .rst_ni (resetN),
    .clr_i  (1'b0),
    .inc_i  (miss_start),
    .cnt_o  (missCount)
  );

  sat_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_cnt (
    .clk_i  (clock),
    .rst_ni (resetN),
    .clr_i  (wait_clr),
    .inc_i  (wait_inc),
    .cnt_o  (wait_cnt)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      fillValid_q  <= 1'b0;
      fillData_q   <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fillValid_q <= 1'b0;
          if (miss) begin
            state_q    <= REQ;
            memReq_q   <= 1'b1;
            memWe_q    <= memWriteIn;
            memAddr_q  <= addrIn;
            memWdata_q <= wdataIn;
          end
        end
        REQ: begin
          if (memAck) begin
            state_q     <= FILL;
            memReq_q    <= 1'b0;
            fillValid_q <= ~memWe_q;
            if (!memWe_q) begin
              fillData_q <= memRdata;
            end
          end else if (wait_expired) begin
            state_q      <= ERROR;
            memReq_q     <= 1'b0;
            timeoutErr_q <= 1'b1;
          end
        end
        FILL: begin
          // Exactly one release cycle; any miss still presented is not re-checked here.
          state_q     <= IDLE;
          fillValid_q <= 1'b0;
        end
        ERROR: begin
          state_q <= ERROR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = miss;
      REQ:     stall = 1'b1;
      FILL:    stall = 1'b0;
      ERROR:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign bubble = stall;
  assign pcSrc  = branchIn & zeroFlagIn & ~stall;
  assign flush  = branchIn & zeroFlagIn & ~stall;

  assign memReq     = memReq_q;
  assign memWe      = memWe_q;
  assign memAddr    = memAddr_q;
  assign memWdata   = memWdata_q;
  assign fillValid  = fillValid_q;
  assign fillData   = fillData_q;
  assign timeoutErr = timeoutErr_q;

endmodule

// File: tb/tb_mem_stage_controller.sv
// tb_mem_stage_controller: self-checking bench for mem_stage_controller.
// A transaction-level reference model predicts every output each cycle; the
// directed scenarios add literal expectations for the key timing points.
module tb_mem_stage_controller;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TO      = 8;
  localparam int unsigned CW      = 8;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          memReadIn = 1'b0, memWriteIn = 1'b0, hitIn = 1'b0;
  logic          branchIn = 1'b0, zeroFlagIn = 1'b0;
  logic [AW-1:0] addrIn = '0;
  logic [DW-1:0] wdataIn = '0;
  logic          memAck = 1'b0;
  logic [DW-1:0] memRdata = '0;

  logic          stall, bubble, pcSrc, flush, memReq, memWe, fillValid, timeoutErr;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata, fillData;
  logic [CW-1:0] missCount;

  int checks = 0;
  int failures = 0;

  mem_stage_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock      (clock),
    .resetN     (resetN),
    .memReadIn  (memReadIn),
    .memWriteIn (memWriteIn),
    .hitIn      (hitIn),
    .branchIn   (branchIn),
    .zeroFlagIn (zeroFlagIn),
    .addrIn     (addrIn),
    .wdataIn    (wdataIn),
    .memAck     (memAck),
    .memRdata   (memRdata),
    .stall      (stall),
    .bubble     (bubble),
    .pcSrc      (pcSrc),
    .flush      (flush),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWdata   (memWdata),
    .fillValid  (fillValid),
    .fillData   (fillData),
    .timeoutErr (timeoutErr),
    .missCount  (missCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  bit            m_busy = 0;   // request outstanding to backing memory
  bit            m_fill = 0;   // current cycle is the release cycle
  bit            m_dead = 0;   // timed out, waiting for reset
  int            m_wait = 0;   // REQ cycles already spent without ack
  bit            m_we = 0, m_fvalid = 0, m_terr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_fdata = '0;
  int unsigned   m_cnt = 0;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      m_busy <= 0; m_fill <= 0; m_dead <= 0; m_wait <= 0;
      m_we <= 0; m_fvalid <= 0; m_terr <= 0;
      m_addr <= '0; m_wdata <= '0; m_fdata <= '0; m_cnt <= 0;
    end else if (m_dead) begin
      m_dead <= 1;
    end else if (m_busy) begin
      if (memAck) begin
        m_busy   <= 0;
        m_fill   <= 1;
        m_fvalid <= !m_we;
        if (!m_we) m_fdata <= memRdata;
      end else if (m_wait + 1 == int'(TO)) begin
        m_busy <= 0;
        m_dead <= 1;
        m_terr <= 1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (m_fill) begin
      m_fill   <= 0;
      m_fvalid <= 0;
    end else if ((memReadIn || memWriteIn) && !hitIn) begin
      m_busy  <= 1;
      m_wait  <= 0;
      m_addr  <= addrIn;
      m_wdata <= wdataIn;
      m_we    <= memWriteIn;
      if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clock) begin
    logic miss_now, exp_stall, exp_br;
    miss_now  = (memReadIn || memWriteIn) && !hitIn;
    exp_stall = m_dead || m_busy || (!m_fill && miss_now);
    exp_br    = branchIn && zeroFlagIn && !exp_stall;
    chk("stall",      64'(stall),      64'(exp_stall));
    chk("bubble",     64'(bubble),     64'(exp_stall));
    chk("pcSrc",      64'(pcSrc),      64'(exp_br));
    chk("flush",      64'(flush),      64'(exp_br));
    chk("memReq",     64'(memReq),     64'(m_busy));
    chk("memWe",      64'(memWe),      64'(m_we));
    chk("memAddr",    64'(memAddr),    64'(m_addr));
    chk("memWdata",   64'(memWdata),   64'(m_wdata));
    chk("fillValid",  64'(fillValid),  64'(m_fvalid));
    chk("fillData",   64'(fillData),   64'(m_fdata));
    chk("timeoutErr", 64'(timeoutErr), 64'(m_terr));
    chk("missCount",  64'(missCount),  64'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    memReadIn = 0; memWriteIn = 0; hitIn = 0;
    branchIn = 0; zeroFlagIn = 0; memAck = 0;
  endtask

  initial begin
    int stall_cycles;

    // Reset state
    resetN = 0;
    @(negedge clock);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_memReq", 64'(memReq), 64'd0);
    chk("rst_missCount", 64'(missCount), 64'd0);
    chk("rst_memAddr", 64'(memAddr), 64'd0);
    step();
    resetN = 1;

    // 1: hits never stall
    memReadIn = 1; hitIn = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hit_stall", 64'(stall), 64'd0);
      chk("hit_memReq", 64'(memReq), 64'd0);
      step();
    end
    chk("hit_missCount", 64'(missCount), 64'd0);

    // 2: read miss, ack in the third REQ cycle
    stall_cycles = 0;
    memReadIn = 1; hitIn = 0; addrIn = 32'h0000_0040;
    for (int i = 0; i < 6; i++) begin
      memAck   = (i == 3);
      memRdata = (i == 3) ? 32'hDEAD_BEEF : $urandom;
      if (i == 5) idle_inputs();
      @(negedge clock);
      if (stall) stall_cycles++;
      if (i == 2) begin
        chk("rd_memAddr", 64'(memAddr), 64'h40);
        chk("rd_memWe", 64'(memWe), 64'd0);
        chk("rd_memReq", 64'(memReq), 64'd1);
      end
      if (i == 4) begin
        chk("rd_fillValid", 64'(fillValid), 64'd1);
        chk("rd_fillData", 64'(fillData), 64'hDEAD_BEEF);
        chk("rd_fill_stall", 64'(stall), 64'd0);
      end
      step();
    end
    chk("rd_stall_cycles", 64'(stall_cycles), 64'd4);
    chk("rd_missCount", 64'(missCount), 64'd1);

    // 3: write miss, ack in the first REQ cycle
    stall_cycles = 0;
    memWriteIn = 1; hitIn = 0; addrIn = 32'h0000_0080; wdataIn = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      memAck = (i == 1);
      memRdata = $urandom;
      if (i == 3) idle_inputs();
      @(negedge clock);
      if (stall) stall_cycles++;
      if (i == 1) begin
        chk("wr_memWe", 64'(memWe), 64'd1);
        chk("wr_memWdata", 64'(memWdata), 64'h1234_5678);
      end
      if (i == 2) begin
        chk("wr_fillValid", 64'(fillValid), 64'd0);
        chk("wr_fill_stall", 64'(stall), 64'd0);
      end
      step();
    end
    chk("wr_stall_cycles", 64'(stall_cycles), 64'd2);
    chk("wr_missCount", 64'(missCount), 64'd2);

    // 4: taken branch held behind a read miss
    memReadIn = 1; hitIn = 0; branchIn = 1; zeroFlagIn = 1; addrIn = 32'h100;
    for (int i = 0; i < 5; i++) begin
      memAck = (i == 2);
      if (i == 4) idle_inputs();
      @(negedge clock);
      if (i < 3) chk("br_pcSrc_stalled", 64'(pcSrc), 64'd0);
      if (i == 3) begin
        chk("br_pcSrc_fill", 64'(pcSrc), 64'd1);
        chk("br_flush_fill", 64'(flush), 64'd1);
      end
      step();
    end

    // 5: timeout after TO REQ cycles, ack afterwards ignored, reset clears
    memReadIn = 1; hitIn = 0; addrIn = 32'h200;
    for (int i = 0; i < 12; i++) begin
      memAck = (i == 10);
      if (i == 1) idle_inputs();
      @(negedge clock);
      if (i == int'(TO)) begin
        chk("to_err_before", 64'(timeoutErr), 64'd0);
        chk("to_req_before", 64'(memReq), 64'd1);
      end
      if (i == int'(TO) + 1 || i == 11) begin
        chk("to_err", 64'(timeoutErr), 64'd1);
        chk("to_stall", 64'(stall), 64'd1);
        chk("to_memReq", 64'(memReq), 64'd0);
      end
      step();
    end
    idle_inputs();
    resetN = 0;
    @(negedge clock);
    chk("to_rst_err", 64'(timeoutErr), 64'd0);
    chk("to_rst_stall", 64'(stall), 64'd0);
    chk("to_rst_missCount", 64'(missCount), 64'd0);
    step();
    resetN = 1;

    // 6a: asynchronous reset in the middle of REQ
    memReadIn = 1; hitIn = 0; addrIn = 32'h300;
    step();
    chk("async_req_before", 64'(memReq), 64'd1);
    #2;
    resetN = 0;
    #1;
    chk("async_memReq", 64'(memReq), 64'd0);
    chk("async_missCount", 64'(missCount), 64'd0);
    chk("async_memAddr", 64'(memAddr), 64'd0);
    idle_inputs();
    step();
    resetN = 1;

    // 6b: miss counter saturation
    memReadIn = 1; hitIn = 0; memAck = 1;
    for (int i = 0; i < 3 * (int'(CNT_MAX) + 10); i++) begin
      addrIn = $urandom;
      memRdata = $urandom;
      step();
    end
    @(negedge clock);
    chk("sat_missCount", 64'(missCount), 64'(CNT_MAX));
    idle_inputs();
    resetN = 0;
    step();
    resetN = 1;

    // Randomized traffic, reset whenever the model reports a timeout
    for (int i = 0; i < 1500; i++) begin
      memReadIn  = ($urandom_range(0, 2) == 0);
      memWriteIn = ($urandom_range(0, 3) == 0);
      hitIn      = ($urandom_range(0, 1) == 0);
      branchIn   = $urandom_range(0, 1);
      zeroFlagIn = $urandom_range(0, 1);
      addrIn     = $urandom;
      wdataIn    = $urandom;
      memAck     = ($urandom_range(0, 2) != 0);
      memRdata   = $urandom;
      resetN     = !(m_dead && ($urandom_range(0, 2) == 0));
      step();
    end
    idle_inputs();
    resetN = 1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
